// File: rtl/syn_lb_host_bridge.sv
// Host-command to local-bus bridge: one outstanding transaction, completion wait with
// timeout, and a response held until the host takes it.
module syn_lb_host_bridge #(
  parameter int unsigned                  P_LB_DWIDTH = 32,
  parameter int unsigned                  P_LB_AWIDTH = 16,
  parameter int unsigned                  P_TIMEOUT   = 64,
  parameter logic [P_LB_DWIDTH-1:0]       P_ERR_DATA  = 32'hDEAD_DEAD
) (
  input  logic                   clk_ir,
  input  logic                   rst_ih,
  input  logic                   cmd_valid_ih,
  output logic                   cmd_ready_oh,
  input  logic                   cmd_wr_ih,
  input  logic [P_LB_AWIDTH-1:0] cmd_addr_id,
  input  logic [P_LB_DWIDTH-1:0] cmd_data_id,
  output logic                   rsp_valid_oh,
  input  logic                   rsp_ready_ih,
  output logic                   rsp_wr_oh,
  output logic                   rsp_err_oh,
  output logic [P_LB_DWIDTH-1:0] rsp_data_od,
  output logic                   lb_rd_en_oh,
  output logic                   lb_wr_en_oh,
  output logic [P_LB_AWIDTH-1:0] lb_addr_od,
  output logic [P_LB_DWIDTH-1:0] lb_wr_data_od,
  input  logic                   lb_rd_valid_ih,
  input  logic                   lb_wr_valid_ih,
  input  logic [P_LB_DWIDTH-1:0] lb_rd_data_id,
  output logic                   busy_oh,
  output logic [15:0]            timeout_cnt_od
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [7:0] LastWaitCnt = 8'(P_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [7:0]               wait_cnt_q, wait_cnt_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     wr_q, wr_d;
  logic [P_LB_AWIDTH-1:0]   addr_q, addr_d;
  logic [P_LB_DWIDTH-1:0]   wdata_q, wdata_d;
  logic                     rsp_wr_q, rsp_wr_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [P_LB_DWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]              tcnt_q, tcnt_d;
  logic                     done;

  // Next-state, command capture, completion/timeout handling and response capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    tcnt_d      = tcnt_q;
    // Only the valid matching the transaction direction counts as completion.
    done        = wr_q ? lb_wr_valid_ih : lb_rd_valid_ih;
    case (state_q)
      StIdle: begin
        if (cmd_valid_ih && cmd_ready_q) begin
          state_d = StIssue;
          wr_d    = cmd_wr_ih;
          addr_d  = cmd_addr_id;
          wdata_d = cmd_data_id;
        end
      end
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (done) begin
          // Completion wins over a timeout landing in the same cycle.
          state_d    = StResp;
          rsp_wr_d   = wr_q;
          rsp_err_d  = 1'b0;
          rsp_data_d = wr_q ? '0 : lb_rd_data_id;
        end else if (wait_cnt_q == LastWaitCnt) begin
          state_d    = StResp;
          rsp_wr_d   = wr_q;
          rsp_err_d  = 1'b1;
          rsp_data_d = wr_q ? '0 : P_ERR_DATA;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready_ih) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so ready stays low during reset and rises on the first edge after it.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cmd_ready_oh   = cmd_ready_q;
    rsp_valid_oh   = (state_q == StResp);
    rsp_wr_oh      = rsp_wr_q;
    rsp_err_oh     = rsp_err_q;
    rsp_data_od    = rsp_data_q;
    lb_rd_en_oh    = (state_q == StIssue) && !wr_q;
    lb_wr_en_oh    = (state_q == StIssue) && wr_q;
    lb_addr_od     = addr_q;
    lb_wr_data_od  = wdata_q;
    busy_oh        = (state_q != StIdle);
    timeout_cnt_od = tcnt_q;
  end

endmodule

// File: tb/tb_syn_lb_host_bridge.sv
// Scoreboard bench for syn_lb_host_bridge: directed transactions push expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_syn_lb_host_bridge;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [31:0] rsp_data;
  logic        lb_rd_en, lb_wr_en;
  logic [15:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_rd_valid, lb_wr_valid;
  logic [31:0] lb_rd_data;
  logic        busy;
  logic [15:0] timeout_cnt;

  syn_lb_host_bridge dut (
    .clk_ir         (clk),
    .rst_ih         (rst),
    .cmd_valid_ih   (cmd_valid),
    .cmd_ready_oh   (cmd_ready),
    .cmd_wr_ih      (cmd_wr),
    .cmd_addr_id    (cmd_addr),
    .cmd_data_id    (cmd_data),
    .rsp_valid_oh   (rsp_valid),
    .rsp_ready_ih   (rsp_ready),
    .rsp_wr_oh      (rsp_wr),
    .rsp_err_oh     (rsp_err),
    .rsp_data_od    (rsp_data),
    .lb_rd_en_oh    (lb_rd_en),
    .lb_wr_en_oh    (lb_wr_en),
    .lb_addr_od     (lb_addr),
    .lb_wr_data_od  (lb_wr_data),
    .lb_rd_valid_ih (lb_rd_valid),
    .lb_wr_valid_ih (lb_wr_valid),
    .lb_rd_data_id  (lb_rd_data),
    .busy_oh        (busy),
    .timeout_cnt_od (timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_e;
  rsp_t prev_rsp;
  logic prev_valid = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   rise_cyc = -1;
  int   wr_pulses = 0;
  int   rd_pulses = 0;
  int   strobe_cyc = -1;
  logic [15:0] st_addr;
  logic [31:0] st_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Response monitor/scoreboard and local-bus strobe observer.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      if (rsp_valid && prev_valid) check("rsp_stable", {rsp_wr, rsp_err, rsp_data}, prev_rsp);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_fields", {rsp_wr, rsp_err, rsp_data}, exp_e);
        end
      end
      prev_valid = rsp_valid;
      prev_rsp   = {rsp_wr, rsp_err, rsp_data};
      if (lb_wr_en && lb_rd_en) check("both_strobes", 64'd1, 64'd0);
      if (lb_wr_en || lb_rd_en) begin
        if (lb_wr_en) wr_pulses++;
        if (lb_rd_en) rd_pulses++;
        strobe_cyc = cyc;
        st_addr    = lb_addr;
        st_data    = lb_wr_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a command and returns the cycle number seen just after the accepting edge.
  task automatic send(input logic wr, input logic [15:0] a, input logic [31:0] d,
                      output int t);
    int   n;
    logic rdy;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    do begin
      rdy = cmd_ready;
      step();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) check("accept_bound", 64'd0, 64'd1);
    cmd_valid = 1'b0;
    t         = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) check("done_bound", 64'd1, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int wp0;
    int rp0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b1;
    lb_rd_valid = 1'b0;
    lb_wr_valid = 1'b0;
    lb_rd_data  = '0;

    // Reset values.
    #1;
    check("reset_ctrl", {cmd_ready, rsp_valid, rsp_wr, rsp_err, busy, lb_rd_en, lb_wr_en}, 0);
    check("reset_data", {lb_addr, lb_wr_data, rsp_data, timeout_cnt}, 0);
    repeat (3) step();
    check("ready_in_reset", cmd_ready, 0);
    #3 rst = 1'b0;
    check("ready_before_edge", cmd_ready, 0);
    step();
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);

    // Write 0x1004, completion 3 cycles after the strobe.
    wp0 = wr_pulses;
    rp0 = rd_pulses;
    exp_q.push_back('{wr: 1'b1, err: 1'b0, data: 32'h0});
    send(1'b1, 16'h1004, 32'hA5A5_0001, t);
    repeat (3) step();
    lb_wr_valid = 1'b1;
    step();
    lb_wr_valid = 1'b0;
    wait_done();
    check("wr_pulse_cnt", wr_pulses - wp0, 1);
    check("wr_no_rd_pulse", rd_pulses - rp0, 0);
    check("wr_strobe_cyc", strobe_cyc, t);
    check("wr_strobe_addr", st_addr, 16'h1004);
    check("wr_strobe_data", st_data, 32'hA5A5_0001);
    check("wr_rsp_cyc", rise_cyc, t + 4);
    check("wr_addr_hold", {lb_addr, lb_wr_data}, {16'h1004, 32'hA5A5_0001});

    // Minimum-latency read: strobe one cycle after accept, rsp_valid two cycles after.
    rp0 = rd_pulses;
    exp_q.push_back('{wr: 1'b0, err: 1'b0, data: 32'h1234_5678});
    send(1'b0, 16'h2010, 32'h0, t);
    step();
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h1234_5678;
    step();
    lb_rd_valid = 1'b0;
    lb_rd_data  = 32'hFFFF_0000;
    wait_done();
    check("rd_pulse_cnt", rd_pulses - rp0, 1);
    check("rd_strobe", {strobe_cyc, st_addr}, {t, 16'h2010});
    check("rd_rsp_cyc", rise_cyc, t + 2);

    // Read with no completion: 64 WAIT cycles then error response.
    exp_q.push_back('{wr: 1'b0, err: 1'b1, data: 32'hDEAD_DEAD});
    send(1'b0, 16'h2020, 32'h0, t);
    wait_done();
    check("to_rsp_cyc", rise_cyc, t + 1 + TO);
    check("to_cnt_1", timeout_cnt, 16'd1);

    // Stray valids in IDLE, then a write answered only by the read valid.
    lb_rd_valid = 1'b1;
    lb_wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_idle", {busy, cmd_ready, rsp_valid}, 3'b010);
    end
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    exp_q.push_back('{wr: 1'b1, err: 1'b1, data: 32'h0});
    send(1'b1, 16'h3000, 32'h0000_0055, t);
    lb_rd_valid = 1'b1;
    wait_done();
    lb_rd_valid = 1'b0;
    check("wrong_valid_cyc", rise_cyc, t + 1 + TO);
    check("to_cnt_2", timeout_cnt, 16'd2);

    // Matching valid in the timeout cycle: completion wins.
    exp_q.push_back('{wr: 1'b0, err: 1'b0, data: 32'hCAFE_F00D});
    send(1'b0, 16'h2030, 32'h0, t);
    repeat (TO) step();
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'hCAFE_F00D;
    step();
    lb_rd_valid = 1'b0;
    wait_done();
    check("edge_rsp_cyc", rise_cyc, t + 1 + TO);
    check("edge_to_cnt", timeout_cnt, 16'd2);

    // Response back-pressure with the next command already waiting.
    rsp_ready = 1'b0;
    exp_q.push_back('{wr: 1'b0, err: 1'b0, data: 32'h0BAD_BEEF});
    send(1'b0, 16'h2040, 32'h0, t);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 16'h4000;
    cmd_data  = 32'h600D_0004;
    step();
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h0BAD_BEEF;
    step();
    lb_rd_valid = 1'b0;
    lb_rd_data  = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check("stall_ctrl", {rsp_valid, cmd_ready, busy}, 3'b101);
      step();
    end
    exp_q.push_back('{wr: 1'b1, err: 1'b0, data: 32'h0});
    rsp_ready = 1'b1;
    step();
    check("post_hs_ready", {rsp_valid, cmd_ready}, 2'b01);
    step();
    cmd_valid = 1'b0;
    check("next_accept", {busy, lb_wr_en, lb_addr}, {2'b11, 16'h4000});
    repeat (2) step();
    lb_wr_valid = 1'b1;
    step();
    lb_wr_valid = 1'b0;
    wait_done();
    check("next_wr_data", st_data, 32'h600D_0004);

    // Reset while waiting on a read, followed by a late completion.
    send(1'b0, 16'h2050, 32'h0, t);
    repeat (2) step();
    #2 rst = 1'b1;
    wp0 = wr_pulses;
    rp0 = rd_pulses;
    #1;
    check("mid_rst_ctrl", {cmd_ready, rsp_valid, rsp_wr, rsp_err, busy, lb_rd_en, lb_wr_en}, 0);
    check("mid_rst_data", {lb_addr, lb_wr_data, rsp_data, timeout_cnt}, 0);
    step();
    check("mid_rst_ready", cmd_ready, 0);
    #2 rst = 1'b0;
    lb_rd_valid = 1'b1;
    lb_rd_data  = 32'h7777_7777;
    step();
    lb_rd_valid = 1'b0;
    check("post_rst_ready", {cmd_ready, busy}, 2'b10);
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", {rsp_valid, busy, lb_rd_en, lb_wr_en}, 0);
    end
    check("post_rst_strobes", {wr_pulses - wp0, rd_pulses - rp0}, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/syn_lb_host_bridge.md
SYN_LB_HOST_BRIDGE -- requirements
Module: syn_lb_host_bridge

Interface
REQ-001 Parameters SHALL be, one per line:
- P_LB_DWIDTH, 32, local-bus data width.
- P_LB_AWIDTH, 16, local-bus address width; bits [15:12] select the cortex block.
- P_TIMEOUT, 64, maximum WAIT cycles before error, range 2..255.
- P_ERR_DATA, 32'hDEAD_DEAD, read data returned on timeout.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_ir, in, 1, sole clock; one clock domain.
- rst_ih, in, 1, reset; asynchronous, active-high.
- cmd_valid_ih, in, 1, host command valid.
- cmd_ready_oh, out, 1, bridge accepts command.
- cmd_wr_ih, in, 1, 1 = write, 0 = read.
- cmd_addr_id, in, 16, command address.
- cmd_data_id, in, 32, write data.
- rsp_valid_oh, out, 1, response valid.
- rsp_ready_ih, in, 1, host accepts response.
- rsp_wr_oh, out, 1, response belongs to a write.
- rsp_err_oh, out, 1, transaction timed out.
- rsp_data_od, out, 32, read data; 0 for writes.
- lb_rd_en_oh, out, 1, local-bus read strobe.
- lb_wr_en_oh, out, 1, local-bus write strobe.
- lb_addr_od, out, 16, local-bus address.
- lb_wr_data_od, out, 32, local-bus write data.
- lb_rd_valid_ih, in, 1, read completion from the cortex.
- lb_wr_valid_ih, in, 1, write completion from the cortex.
- lb_rd_data_id, in, 32, read data from the cortex.
- busy_oh, out, 1, high whenever FSM is not IDLE.
- timeout_cnt_od, out, 16, saturating count of timed-out transactions.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, all registered.
REQ-004 cmd_ready_oh SHALL be high only in IDLE; a command is accepted when cmd_valid_ih and cmd_ready_oh are both high on a clock edge.
REQ-005 On accept (cycle T), the bridge SHALL register cmd_wr, cmd_addr and cmd_data, and enter ISSUE at T+1.
REQ-006 In ISSUE, the bridge SHALL assert exactly one of lb_wr_en_oh / lb_rd_en_oh for exactly one cycle, then enter WAIT.
REQ-007 lb_addr_od and lb_wr_data_od SHALL hold the registered values from ISSUE until the next accept.
REQ-008 In WAIT, a write SHALL complete only on lb_wr_valid_ih and a read only on lb_rd_valid_ih; the non-matching valid SHALL be ignored.
REQ-009 Completion valids SHALL be sampled only in WAIT; valids in IDLE, ISSUE or RESP SHALL be ignored, with no state change.
REQ-010 On completion in WAIT cycle W, the bridge SHALL enter RESP at W+1 with rsp_err_oh=0, rsp_wr_oh=cmd_wr, and rsp_data_od = lb_rd_data_id captured at W for reads, 0 for writes.
REQ-011 The WAIT counter SHALL clear on entry and increment each WAIT cycle. If no matching valid has arrived when the counter equals P_TIMEOUT-1, the bridge SHALL enter RESP with rsp_err_oh=1 and rsp_data_od = P_ERR_DATA for reads, 0 for writes.
REQ-012 A timeout SHALL increment timeout_cnt_od, saturating at 16'hFFFF.
REQ-013 If the matching valid arrives in the timeout cycle, completion SHALL win: no error and no count.
REQ-014 In RESP, rsp_valid_oh SHALL be high, and all rsp_* outputs SHALL stay stable until rsp_ready_ih. On handshake the FSM SHALL go to IDLE, with cmd_ready_oh high on the next cycle.
REQ-015 Minimum read latency SHALL be: accept at T, strobe at T+1, valid at T+2, rsp_valid at T+3.
REQ-016 rsp_valid_oh SHALL be low outside RESP. rsp_data_od, rsp_wr_oh and rsp_err_oh SHALL hold their last values outside RESP.

Reset
REQ-017 While rst_ih is high, the block SHALL asynchronously force:
- FSM to IDLE and WAIT counter to 0;
- timeout_cnt_od to 0;
- lb_rd_en_oh, lb_wr_en_oh, rsp_valid_oh, rsp_wr_oh, rsp_err_oh and busy_oh to 0;
- lb_addr_od, lb_wr_data_od and rsp_data_od to 0;
- cmd_ready_oh to 0.
REQ-018 cmd_ready_oh SHALL rise on the first clock edge after rst_ih deasserts.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no response and no strobe. A late completion valid arriving after reset SHALL be ignored per REQ-009.

Verification
REQ-020 Write 0x1004 = 0xA5A5_0001, with lb_wr_valid_ih 3 cycles after the strobe -> one lb_wr_en_oh pulse with addr 0x1004 and data 0xA5A5_0001, then rsp_valid with wr=1, err=0, data=0.
REQ-021 Read 0x2010, with lb_rd_valid_ih and data 0x1234_5678 one cycle after the strobe -> rsp_valid at T+3 with data 0x1234_5678, err=0.
REQ-022 Read with no completion and P_TIMEOUT=64 -> rsp_valid exactly 64 WAIT cycles later with err=1, data 0xDEAD_DEAD, and timeout_cnt_od=1.
REQ-023 Write answered only by lb_rd_valid_ih, plus stray valids in IDLE -> no completion; timeout error response; FSM is never disturbed from IDLE.
REQ-024 rsp_ready_ih held low 10 cycles, with cmd_valid_ih held high -> rsp outputs stable; cmd_ready_oh stays low until the handshake; the next command is accepted the cycle after.
REQ-025 rst_ih pulsed in WAIT, followed by a late lb_rd_valid_ih -> all outputs at reset values, no rsp_valid, cmd_ready_oh=1 after reset.
